// File: rtl/tick_scheduler_if.sv
// Configuration write port of tick_scheduler: valid/ready handshake carrying
// the target channel, the clk_div tap index and the enable value.
//   master : drives cfg_valid, cfg_ch, cfg_tap, cfg_en; observes cfg_ready
//   slave  : observes the write fields; drives cfg_ready
interface tick_scheduler_if #(
    parameter int unsigned TAP_W = 5
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [TAP_W-1:0] cfg_tap;
    logic             cfg_en;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_tap,
        output cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_tap,
        input  cfg_en,
        output cfg_ready
    );
endinterface

// File: rtl/tick_scheduler.sv
// tick_scheduler: derives per-channel enable ticks from rising edges of a
// selectable bit of a free-running divider count, arbitrating simultaneous
// ticks round-robin so at most one channel pulses per cycle.
//   clk      : system clock, all state updates on posedge
//   rst      : asynchronous active-low reset
//   clk_div  : free-running divider count, sampled every cycle
//   cfg      : configuration write port (slave side), one write per two cycles
//   tick     : registered one-hot (or zero) single-cycle pulse per channel
//   tick_id  : index of the last channel that pulsed
//   overrun  : sticky per-channel flag, a rise arrived while a tick was queued
module tick_scheduler #(
    parameter int unsigned NCH   = 4,   // only 4 channels are supported
    parameter int unsigned TAP_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         clk_div,
    tick_scheduler_if.slave     cfg,
    output logic [NCH-1:0]      tick,
    output logic [1:0]          tick_id,
    output logic [NCH-1:0]      overrun
);

    localparam int unsigned CH_W = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ARM  = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [CH_W-1:0]   arm_ch,  arm_ch_n;
    logic [TAP_W-1:0]  arm_tap, arm_tap_n;
    logic              arm_en,  arm_en_n;

    logic [NCH-1:0][TAP_W-1:0] tap, tap_n;
    logic [NCH-1:0]            en, en_n;
    logic [NCH-1:0]            prev, prev_n;
    logic [NCH-1:0]            pending, pending_n;
    logic [NCH-1:0]            overrun_n;
    logic [CH_W-1:0]           last_grant;

    logic [NCH-1:0]  arming;
    logic [NCH-1:0]  sel;
    logic [NCH-1:0]  rise;
    logic [NCH-1:0]  req;
    logic [NCH-1:0]  grant_oh;
    logic [CH_W-1:0] grant_id;
    logic            grant_vld;

    // Config FSM state register; cfg_ready is registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            arm_ch        <= '0;
            arm_tap       <= '0;
            arm_en        <= 1'b0;
            cfg.cfg_ready <= 1'b1;
        end else begin
            state         <= state_n;
            arm_ch        <= arm_ch_n;
            arm_tap       <= arm_tap_n;
            arm_en        <= arm_en_n;
            cfg.cfg_ready <= (state_n == S_IDLE);
        end
    end

    // Config FSM next state: accept a write in IDLE, apply it for one ARM cycle
    always_comb begin
        state_n   = state;
        arm_ch_n  = arm_ch;
        arm_tap_n = arm_tap;
        arm_en_n  = arm_en;
        case (state)
            S_IDLE: begin
                if (cfg.cfg_valid && cfg.cfg_ready) begin
                    state_n   = S_ARM;
                    arm_ch_n  = cfg.cfg_ch;
                    arm_tap_n = cfg.cfg_tap;
                    arm_en_n  = cfg.cfg_en;
                end
            end
            S_ARM:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Rise detection; the channel being armed is frozen out for the cycle
    always_comb begin
        arming = '0;
        sel    = '0;
        rise   = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            arming[ch] = (state == S_ARM) && (arm_ch == CH_W'(ch));
            sel[ch]    = clk_div[tap[ch]];
            rise[ch]   = en[ch] && !arming[ch] && sel[ch] && !prev[ch];
        end
        req = pending & ~arming;
    end

    // Round-robin grant, searching upward from the channel after last_grant
    always_comb begin
        logic [CH_W-1:0] idx;
        grant_oh  = '0;
        grant_id  = last_grant;
        grant_vld = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = last_grant + CH_W'(k);
            if (!grant_vld && req[idx]) begin
                grant_vld     = 1'b1;
                grant_id      = idx;
                grant_oh[idx] = 1'b1;
            end
        end
    end

    // Per-channel next state; a queued tick survives a coinciding rise+grant
    always_comb begin
        tap_n     = tap;
        en_n      = en;
        prev_n    = sel;
        pending_n = rise | (pending & ~grant_oh);
        overrun_n = overrun | (rise & pending & ~grant_oh);
        for (int ch = 0; ch < NCH; ch++) begin
            if (arming[ch]) begin
                // Preloading prev from the new tap prevents a spurious tick
                tap_n[ch]     = arm_tap;
                en_n[ch]      = arm_en;
                prev_n[ch]    = clk_div[arm_tap];
                pending_n[ch] = 1'b0;
                overrun_n[ch] = 1'b0;
            end
        end
    end

    // Channel registers and registered tick outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap        <= '0;
            en         <= '0;
            prev       <= '0;
            pending    <= '0;
            overrun    <= '0;
            tick       <= '0;
            tick_id    <= '0;
            last_grant <= CH_W'(NCH - 1);
        end else begin
            tap     <= tap_n;
            en      <= en_n;
            prev    <= prev_n;
            pending <= pending_n;
            overrun <= overrun_n;
            tick    <= grant_oh;
            if (grant_vld) begin
                tick_id    <= grant_id;
                last_grant <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Testbench for tick_scheduler: directed scenarios plus randomized traffic,
// checked against a cycle-level reference model through a tick scoreboard.
module tb_tick_scheduler;

    localparam int unsigned NCH   = 4;
    localparam int unsigned TAP_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [31:0]      clk_div = '0;
    logic [NCH-1:0]   tick;
    logic [1:0]       tick_id;
    logic [NCH-1:0]   overrun;

    tick_scheduler_if #(.TAP_W(TAP_W)) cfg_bus ();

    tick_scheduler #(.NCH(NCH), .TAP_W(TAP_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_div (clk_div),
        .cfg     (cfg_bus.slave),
        .tick    (tick),
        .tick_id (tick_id),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int ticks_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int ch;
        int cyc;
    } exp_t;
    exp_t expq[$];

    logic [4:0] m_tap [4];
    bit         m_en  [4];
    bit         m_prev[4];
    bit         m_pend[4];
    bit         m_ovr [4];
    int         m_last;
    int         m_arm;     // channel being armed this cycle, -1 if none
    int         m_tid;
    logic [4:0] l_tap;
    bit         l_en;

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin
            m_tap[c] = '0; m_en[c] = 0; m_prev[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
        end
        m_last = 3;
        m_arm  = -1;
        m_tid  = 0;
        l_tap  = '0;
        l_en   = 0;
        expq.delete();
    endfunction

    function automatic void model_step();
        int  g;
        bit  b, r;
        g = -1;
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (g < 0 && m_pend[c] && c != m_arm) g = c;
        end
        for (int c = 0; c < 4; c++) begin
            if (c == m_arm) begin
                m_tap[c]  = l_tap;
                m_en[c]   = l_en;
                m_prev[c] = clk_div[l_tap];
                m_pend[c] = 0;
                m_ovr[c]  = 0;
            end else begin
                b = clk_div[m_tap[c]];
                r = m_en[c] && b && !m_prev[c];
                if (r && m_pend[c] && c != g) m_ovr[c] = 1;
                m_pend[c] = r || (m_pend[c] && c != g);
                m_prev[c] = b;
            end
        end
        if (g >= 0) begin
            expq.push_back('{ch: g, cyc: cyc});
            m_last = g;
            m_tid  = g;
        end
        if (m_arm < 0 && cfg_bus.cfg_valid) begin
            m_arm = int'(cfg_bus.cfg_ch);
            l_tap = cfg_bus.cfg_tap;
            l_en  = cfg_bus.cfg_en;
        end else begin
            m_arm = -1;
        end
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (!rst) model_reset();
            else      model_step();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            logic [3:0] exp_tick;
            logic [3:0] exp_ovr;
            exp_t       e;
            @(negedge clk);
            exp_tick = '0;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                exp_tick[e.ch] = 1'b1;
            end
            if (tick != '0) ticks_seen++;
            chk("tick", 32'(tick), 32'(exp_tick));
            chk("tick_id", 32'(tick_id), 32'(m_tid));
            for (int c = 0; c < 4; c++) exp_ovr[c] = m_ovr[c];
            chk("overrun", 32'(overrun), 32'(exp_ovr));
            chk("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(m_arm < 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt(input bit inc = 1'b0);
        @(negedge clk);
        #1;
        if (inc) clk_div = clk_div + 32'd1;
    endtask

    task automatic idle(input int n);
        repeat (n) nxt(1'b0);
    endtask

    task automatic ramp(input int n);
        repeat (n) nxt(1'b1);
    endtask

    task automatic do_reset();
        nxt(1'b0);
        cfg_bus.cfg_valid = 1'b0;
        rst = 1'b0;
        nxt(1'b0);
        rst = 1'b1;
    endtask

    task automatic cfg_write(input int ch, input int tp, input bit e, input bit inc = 1'b0);
        int w;
        w = 0;
        nxt(inc);
        while (!cfg_bus.cfg_ready && w < 10) begin
            nxt(inc);
            w++;
        end
        if (w >= 10) begin
            n_checks++;
            n_err++;
            $display("FAIL cfg_ready_timeout: ready stuck low after %0d cycles", w);
        end
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch    = 2'(ch);
        cfg_bus.cfg_tap   = 5'(tp);
        cfg_bus.cfg_en    = e;
        nxt(inc);
        cfg_bus.cfg_valid = 1'b0;
    endtask

    initial begin
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_ch    = '0;
        cfg_bus.cfg_tap   = '0;
        cfg_bus.cfg_en    = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(2);

        // ch0 tap 2 ramp: one tick every 8 cycles
        cfg_write(0, 2, 1'b1);
        ramp(48);

        // all channels tap 3: simultaneous rise served 0,1,2,3
        do_reset();
        clk_div = '0;
        for (int c = 0; c < 4; c++) cfg_write(c, 3, 1'b1);
        ramp(40);

        // tap 0 contention: ch1 overruns, rewrite clears it
        do_reset();
        clk_div = '0;
        cfg_write(0, 0, 1'b1);
        cfg_write(2, 0, 1'b1);
        cfg_write(3, 0, 1'b1);
        ramp(3);
        cfg_write(1, 0, 1'b1, 1'b1);
        ramp(16);
        cfg_write(1, 0, 1'b1, 1'b1);
        idle(4);

        // tap change with bit 5 steady high: no spurious tick on ch2
        do_reset();
        clk_div = 32'h30;
        cfg_write(2, 4, 1'b1);
        idle(3);
        cfg_write(2, 5, 1'b1);
        idle(5);
        ramp(70);

        // wrap-around on tap 31, then reset with ch0 pending
        do_reset();
        clk_div = 32'hFFFF_FFFF;
        cfg_write(3, 31, 1'b1);
        idle(4);
        clk_div = 32'h0;
        idle(4);
        cfg_write(0, 0, 1'b1);
        idle(2);
        nxt(1'b0);
        clk_div = 32'h1;
        do_reset();
        idle(6);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            int r;
            nxt(1'b0);
            r = int'($urandom_range(0, 99));
            if (r < 70)      clk_div = clk_div + 32'd1;
            else if (r < 80) clk_div = $urandom;
            cfg_bus.cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_bus.cfg_ch    = 2'($urandom_range(0, 3));
            cfg_bus.cfg_tap   = 5'($urandom_range(0, 6));
            cfg_bus.cfg_en    = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) != 0);
        end
        nxt(1'b0);
        rst = 1'b1;
        cfg_bus.cfg_valid = 1'b0;
        idle(5);

        chk("ticks_observed", 32'(ticks_seen > 20), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
